// File: rtl/mips_core_pkg.sv
// Shared types for the MIPS core memory subsystem: access type, arbiter owner and arbiter state.
package mips_core_pkg;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } MemAccessType;

    typedef enum logic {
        OWNER_ICACHE = 1'b0,
        OWNER_DCACHE = 1'b1
    } MemOwner;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ADDR,
        ARB_RDATA,
        ARB_WDATA
    } MemArbState;

    // A single-beat burst still needs one counter bit.
    function automatic int beat_cnt_width(int burst_len);
        return (burst_len > 1) ? $clog2(burst_len) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_beat_counter.sv
// Beat counter for the memory arbiter: clears or increments, flags the final beat of a burst.
module mem_arb_beat_counter
    import mips_core_pkg::*;
#(
    parameter int BURST_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic inc_i,
    output logic terminal_o
);

    localparam int CNT_W = beat_cnt_width(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign terminal_o = (cnt_q == LAST_BEAT);

    // NOTE: cnt_d gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = terminal_o ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between I-cache refills and D-cache refills/writebacks.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; default is fixed D-cache priority.
module cache_mem_arbiter
    import mips_core_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req_valid,
    output logic                  i_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    output logic                  i_rd_valid,
    output logic                  i_rd_last,
    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    input  logic                  d_req_type,
    input  logic                  d_wr_valid,
    output logic                  d_wr_ready,
    input  logic [DATA_WIDTH-1:0] d_wr_data,
    output logic                  d_rd_valid,
    output logic                  d_rd_last,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic                  mem_req_type,
    output logic                  mem_wr_valid,
    input  logic                  mem_wr_ready,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_wr_last,
    input  logic                  mem_rd_valid,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  busy
);

    MemArbState            state_q, state_d;
    MemOwner               owner_q, owner_d;
    MemAccessType          type_q, type_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
`ifdef ARB_ROUND_ROBIN_EN
    MemOwner               last_owner_q, last_owner_d;
`endif

    MemOwner grant_owner;
    logic    grant_valid;
    logic    cnt_clear, cnt_inc, cnt_terminal;
    logic    wr_hs;

    mem_arb_beat_counter #(.BURST_LEN(BURST_LEN)) u_beat_cnt (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (cnt_clear),
        .inc_i      (cnt_inc),
        .terminal_o (cnt_terminal)
    );

    assign rd_data      = mem_rd_data;
    assign mem_wr_data  = d_wr_data;
    assign mem_req_addr = addr_q;
    assign mem_req_type = type_q;
    assign busy         = (state_q != ARB_IDLE);
    assign wr_hs        = d_wr_valid && mem_wr_ready;

    // No grant while rst is high, so no requester sees a handshake that reset then discards.
    assign grant_valid = (i_req_valid || d_req_valid) && !rst;

    always_comb begin
        grant_owner = OWNER_DCACHE;
        if (i_req_valid && d_req_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_owner = (last_owner_q == OWNER_DCACHE) ? OWNER_ICACHE : OWNER_DCACHE;
`else
            grant_owner = OWNER_DCACHE;
`endif
        end else if (i_req_valid) begin
            grant_owner = OWNER_ICACHE;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        type_d        = type_q;
        addr_d        = addr_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_owner_d  = last_owner_q;
`endif
        i_req_ready   = 1'b0;
        d_req_ready   = 1'b0;
        i_rd_valid    = 1'b0;
        i_rd_last     = 1'b0;
        d_rd_valid    = 1'b0;
        d_rd_last     = 1'b0;
        d_wr_ready    = 1'b0;
        mem_req_valid = 1'b0;
        mem_wr_valid  = 1'b0;
        mem_wr_last   = 1'b0;
        cnt_clear     = 1'b0;
        cnt_inc       = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                cnt_clear = 1'b1;
                if (grant_valid) begin
                    i_req_ready = (grant_owner == OWNER_ICACHE);
                    d_req_ready = (grant_owner == OWNER_DCACHE);
                    owner_d     = grant_owner;
                    addr_d      = (grant_owner == OWNER_DCACHE) ? d_req_addr : i_req_addr;
                    type_d      = (grant_owner == OWNER_DCACHE) ? MemAccessType'(d_req_type)
                                                                : MEM_READ;
`ifdef ARB_ROUND_ROBIN_EN
                    last_owner_d = grant_owner;
`endif
                    state_d     = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = (type_q == MEM_READ) ? ARB_RDATA : ARB_WDATA;
                end
            end
            ARB_RDATA: begin
                i_rd_valid = mem_rd_valid && (owner_q == OWNER_ICACHE);
                d_rd_valid = mem_rd_valid && (owner_q == OWNER_DCACHE);
                i_rd_last  = i_rd_valid && cnt_terminal;
                d_rd_last  = d_rd_valid && cnt_terminal;
                cnt_inc    = mem_rd_valid;
                if (mem_rd_valid && cnt_terminal) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_WDATA: begin
                mem_wr_valid = d_wr_valid;
                d_wr_ready   = mem_wr_ready;
                mem_wr_last  = d_wr_valid && cnt_terminal;
                cnt_inc      = wr_hs;
                if (wr_hs && cnt_terminal) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWNER_ICACHE;
            type_q       <= MEM_READ;
            addr_q       <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q <= OWNER_ICACHE;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            type_q       <= type_d;
            addr_q       <= addr_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus randomized transactions
// against a transaction-level model of grant, address and beat behaviour.
module tb_cache_mem_arbiter;
    import mips_core_pkg::*;

    localparam int BL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid, d_req_valid, d_req_type, d_wr_valid;
    logic [31:0] i_req_addr, d_req_addr, d_wr_data, mem_rd_data;
    logic        mem_req_ready, mem_wr_ready, mem_rd_valid;

    logic        i_req_ready, i_rd_valid, i_rd_last, d_req_ready, d_wr_ready, d_rd_valid, d_rd_last;
    logic        mem_req_valid, mem_req_type, mem_wr_valid, mem_wr_last, busy;
    logic [31:0] rd_data, mem_req_addr, mem_wr_data;

    logic        i_req_ready_1, i_rd_valid_1, i_rd_last_1, d_req_ready_1, d_wr_ready_1;
    logic        d_rd_valid_1, d_rd_last_1, mem_req_valid_1, mem_req_type_1;
    logic        mem_wr_valid_1, mem_wr_last_1, busy_1;
    logic [31:0] rd_data_1, mem_req_addr_1, mem_wr_data_1;

    int tests = 0;
    int fails = 0;
`ifdef ARB_ROUND_ROBIN_EN
    MemOwner last_owner_m;
`endif

    always #5 clk = ~clk;

    cache_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_rd_valid(i_rd_valid), .i_rd_last(i_rd_last),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_type(d_req_type), .d_wr_valid(d_wr_valid), .d_wr_ready(d_wr_ready),
        .d_wr_data(d_wr_data), .d_rd_valid(d_rd_valid), .d_rd_last(d_rd_last),
        .rd_data(rd_data), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_type(mem_req_type),
        .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready), .mem_wr_data(mem_wr_data),
        .mem_wr_last(mem_wr_last), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .busy(busy)
    );

    cache_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_LEN(1)) dut1 (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready_1), .i_req_addr(i_req_addr),
        .i_rd_valid(i_rd_valid_1), .i_rd_last(i_rd_last_1),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready_1), .d_req_addr(d_req_addr),
        .d_req_type(d_req_type), .d_wr_valid(d_wr_valid), .d_wr_ready(d_wr_ready_1),
        .d_wr_data(d_wr_data), .d_rd_valid(d_rd_valid_1), .d_rd_last(d_rd_last_1),
        .rd_data(rd_data_1), .mem_req_valid(mem_req_valid_1), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr_1), .mem_req_type(mem_req_type_1),
        .mem_wr_valid(mem_wr_valid_1), .mem_wr_ready(mem_wr_ready), .mem_wr_data(mem_wr_data_1),
        .mem_wr_last(mem_wr_last_1), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .busy(busy_1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic zero_inputs();
        i_req_valid = 1'b0; d_req_valid = 1'b0; d_req_type = 1'b0; d_wr_valid = 1'b0;
        i_req_addr = '0; d_req_addr = '0; d_wr_data = '0; mem_rd_data = '0;
        mem_req_ready = 1'b0; mem_wr_ready = 1'b0; mem_rd_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        zero_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_owner_m = OWNER_ICACHE;
`endif
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " i_rd_valid"}, i_rd_valid, 0);
        check({tag, " d_rd_valid"}, d_rd_valid, 0);
        check({tag, " i_rd_last"}, i_rd_last, 0);
        check({tag, " d_rd_last"}, d_rd_last, 0);
        check({tag, " mem_wr_valid"}, mem_wr_valid, 0);
        check({tag, " mem_wr_last"}, mem_wr_last, 0);
        check({tag, " d_wr_ready"}, d_wr_ready, 0);
    endtask

    task automatic grant_phase(input logic iv, input logic dv, input logic [31:0] ia,
                               input logic [31:0] da, input MemAccessType dt,
                               output MemOwner own, output logic [31:0] ea,
                               output MemAccessType et);
        @(negedge clk);
        i_req_valid = iv; d_req_valid = dv; i_req_addr = ia; d_req_addr = da; d_req_type = dt;
        mem_rd_valid = 1'($urandom); d_wr_valid = 1'($urandom);
        mem_req_ready = 1'($urandom); mem_wr_ready = 1'($urandom);
        if (iv && dv) begin
`ifdef ARB_ROUND_ROBIN_EN
            own = (last_owner_m == OWNER_DCACHE) ? OWNER_ICACHE : OWNER_DCACHE;
`else
            own = OWNER_DCACHE;
`endif
        end else begin
            own = dv ? OWNER_DCACHE : OWNER_ICACHE;
        end
`ifdef ARB_ROUND_ROBIN_EN
        last_owner_m = own;
`endif
        ea = (own == OWNER_DCACHE) ? da : ia;
        et = (own == OWNER_DCACHE) ? dt : MEM_READ;
        #1;
        check("grant i_req_ready", i_req_ready, own == OWNER_ICACHE);
        check("grant d_req_ready", d_req_ready, own == OWNER_DCACHE);
        check("grant busy", busy, 0);
        check("grant mem_req_valid", mem_req_valid, 0);
        check_quiet("grant");
    endtask

    task automatic addr_phase(input int lat, input logic [31:0] ea, input MemAccessType et);
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            mem_req_ready = (c == lat);
            i_req_valid = 1'($urandom); d_req_valid = 1'($urandom);
            mem_rd_valid = 1'b1; mem_rd_data = $urandom;
            d_wr_valid = 1'($urandom); mem_wr_ready = 1'($urandom);
            #1;
            check("addr mem_req_valid", mem_req_valid, 1);
            check("addr mem_req_addr", mem_req_addr, ea);
            check("addr mem_req_type", mem_req_type, et);
            check("addr i_req_ready", i_req_ready, 0);
            check("addr d_req_ready", d_req_ready, 0);
            check("addr busy", busy, 1);
            check_quiet("addr");
        end
    endtask

    task automatic read_beat(input int k, input int gap, input logic [31:0] data,
                             input MemOwner own);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            mem_req_ready = 1'b0; mem_rd_valid = 1'b0;
            i_req_valid = 1'($urandom); d_req_valid = 1'($urandom); d_wr_valid = 1'($urandom);
            #1;
            check("rgap i_rd_valid", i_rd_valid, 0);
            check("rgap d_rd_valid", d_rd_valid, 0);
            check("rgap busy", busy, 1);
        end
        @(negedge clk);
        mem_req_ready = 1'b0; mem_rd_valid = 1'b1; mem_rd_data = data;
        i_req_valid = 1'($urandom); d_req_valid = 1'($urandom);
        d_wr_valid = 1'($urandom); mem_wr_ready = 1'($urandom);
        #1;
        check("rbeat i_rd_valid", i_rd_valid, own == OWNER_ICACHE);
        check("rbeat d_rd_valid", d_rd_valid, own == OWNER_DCACHE);
        check("rbeat i_rd_last", i_rd_last, (own == OWNER_ICACHE) && (k == BL - 1));
        check("rbeat d_rd_last", d_rd_last, (own == OWNER_DCACHE) && (k == BL - 1));
        check("rbeat rd_data", rd_data, data);
        check("rbeat readies", {i_req_ready, d_req_ready}, 0);
        check("rbeat wr side", {mem_wr_valid, d_wr_ready, mem_req_valid}, 0);
    endtask

    task automatic write_phase(input bit directed, input logic [31:0] base,
                               input logic [31:0] step);
        int hs = 0;
        int cyc = 0;
        logic [31:0] exp_data;
        while (hs < BL && cyc < 200) begin
            @(negedge clk);
            mem_req_ready = 1'b0; mem_rd_valid = 1'($urandom); mem_rd_data = $urandom;
            i_req_valid = 1'($urandom); d_req_valid = 1'($urandom);
            exp_data = directed ? base + 32'(hs) * step : $urandom;
            d_wr_data = exp_data;
            d_wr_valid = directed ? 1'b1 : 1'($urandom_range(3, 0) != 0);
            mem_wr_ready = directed ? 1'(cyc & 1) : 1'($urandom);
            #1;
            check("wr mem_wr_valid", mem_wr_valid, d_wr_valid);
            check("wr d_wr_ready", d_wr_ready, mem_wr_ready);
            check("wr mem_wr_data", mem_wr_data, exp_data);
            check("wr mem_wr_last", mem_wr_last, d_wr_valid && (hs == BL - 1));
            check("wr rd forwarded", {i_rd_valid, d_rd_valid}, 0);
            check("wr readies", {i_req_ready, d_req_ready}, 0);
            check("wr busy", busy, 1);
            if (d_wr_valid && mem_wr_ready) hs++;
            cyc++;
        end
        check("wr handshakes within budget", 64'(hs), 64'(BL));
    endtask

    task automatic finish_txn();
        @(negedge clk);
        zero_inputs();
        mem_rd_valid = 1'b1; d_wr_valid = 1'b1; mem_wr_ready = 1'b1;
        #1;
        check("end busy", busy, 0);
        check("end mem_req_valid", mem_req_valid, 0);
        check("end readies", {i_req_ready, d_req_ready}, 0);
        check_quiet("end");
    endtask

    task automatic run_txn(input logic iv, input logic dv, input logic [31:0] ia,
                           input logic [31:0] da, input MemAccessType dt, input int lat,
                           input bit directed, input logic [31:0] base, input logic [31:0] step);
        MemOwner      own;
        logic [31:0]  ea;
        MemAccessType et;
        grant_phase(iv, dv, ia, da, dt, own, ea, et);
        addr_phase(lat, ea, et);
        if (et == MEM_READ) begin
            for (int k = 0; k < BL; k++) begin
                read_beat(k, directed ? 0 : int'($urandom_range(2, 0)),
                          directed ? base + 32'(k) * step : $urandom, own);
            end
        end else begin
            write_phase(directed, base, step);
        end
        finish_txn();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        MemOwner      own;
        logic [31:0]  ea;
        MemAccessType et;
        logic         iv, dv;

        rst = 1'b1;
        zero_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_owner_m = OWNER_ICACHE;
`endif
        #1;
        check("reset busy", busy, 0);
        check("reset mem_req_valid", mem_req_valid, 0);
        check_quiet("reset");

        // I-cache refill at 0x40, address accepted after 2 cycles, beats 0xA0..0xA3.
        run_txn(1'b1, 1'b0, 32'h40, 32'h0, MEM_READ, 2, 1'b1, 32'hA0, 32'h1);

        // Simultaneous requests after reset, then an immediate D re-request with I still waiting.
        do_reset();
        run_txn(1'b1, 1'b1, 32'h1000, 32'h2000, MEM_READ, 0, 1'b0, 32'h0, 32'h0);
        run_txn(1'b1, 1'b1, 32'h1040, 32'h2040, MEM_READ, 0, 1'b0, 32'h0, 32'h0);

        // D-cache writeback at 0x100 with mem_wr_ready toggling.
        run_txn(1'b0, 1'b1, 32'h0, 32'h100, MEM_WRITE, 1, 1'b1, 32'h11, 32'h11);

        // Reset while two beats into a read burst.
        do_reset();
        grant_phase(1'b1, 1'b0, 32'h200, 32'h0, MEM_READ, own, ea, et);
        addr_phase(0, ea, et);
        read_beat(0, 0, 32'hB0, own);
        read_beat(1, 0, 32'hB1, own);
        @(negedge clk);
        zero_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_owner_m = OWNER_ICACHE;
`endif
        #1;
        check("midreset busy", busy, 0);
        check("midreset mem_req_valid", mem_req_valid, 0);
        check_quiet("midreset");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            mem_rd_valid = 1'b1; mem_rd_data = 32'hDEAD_0000 + 32'(c);
            #1;
            check("post-reset rd dropped", {i_rd_valid, d_rd_valid, i_rd_last, d_rd_last}, 0);
            check("post-reset busy", busy, 0);
        end
        finish_txn();

        // Randomized traffic.
        for (int t = 0; t < 24; t++) begin
            iv = 1'($urandom);
            dv = 1'($urandom);
            if (!iv && !dv) iv = 1'b1;
            run_txn(iv, dv, $urandom, $urandom, MemAccessType'(1'($urandom)),
                    int'($urandom_range(3, 0)), 1'b0, 32'h0, 32'h0);
        end

        // Single-beat burst instance.
        do_reset();
        grant_phase(1'b1, 1'b0, 32'h40, 32'h0, MEM_READ, own, ea, et);
        check("bl1 grant i_req_ready", i_req_ready_1, 1);
        addr_phase(1, ea, et);
        check("bl1 mem_req_valid", mem_req_valid_1, 1);
        @(negedge clk);
        mem_req_ready = 1'b0; i_req_valid = 1'b0; d_req_valid = 1'b0;
        mem_rd_valid = 1'b1; mem_rd_data = 32'h5A;
        #1;
        check("bl1 i_rd_valid", i_rd_valid_1, 1);
        check("bl1 i_rd_last", i_rd_last_1, 1);
        check("bl1 rd_data", rd_data_1, 32'h5A);
        check("bl1 d_rd_valid", d_rd_valid_1, 0);
        check("bl4 not last on first beat", i_rd_last, 0);
        @(negedge clk);
        zero_inputs();
        #1;
        check("bl1 busy after beat", busy_1, 0);
        check("bl1 i_rd_valid after beat", i_rd_valid_1, 0);
        do_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
